// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider.
// State encoding and sizing helpers.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ceil(log2(value)), 0 for value <= 1
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << res) < value) begin
                res = res + 1;
            end
        end
        return res;
    endfunction

    // bits needed to count width-1 down to 0, never zero
    function automatic int cnt_width(input int w);
        int c;
        c = clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/divider_iterative_div_step.sv
// One radix-2 restoring division step.
// Shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int width = 48
) (
    input  logic [width:0]   p,
    input  logic             din,
    input  logic [width-1:0] dvs,
    output logic [width:0]   p_nxt,
    output logic             qbit
);

    logic [width:0] shifted;
    logic [width:0] trial;

    // trial subtract; a clear sign bit means the divisor fits
    always_comb begin
        shifted = {p[width-1:0], din};
        trial   = shifted - {1'b0, dvs};
        qbit    = ~trial[width];
        p_nxt   = qbit ? trial : shifted;
    end

endmodule

// File: rtl/divider_iterative.sv
// Sequential unsigned divider, one quotient bit per clock.
// Start/done handshake, results held until the next accepted start.
module divider_iterative
    import divider_pkg::*;
#(
    parameter int width = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] q,
    output logic [width-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(width);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [width-1:0] dvd;
    logic [width-1:0] dvs;
    logic [width:0]   p;
    logic [width:0]   p_nxt;
    logic             qbit;
    logic [width-1:0] dvd_nxt;

    div_step #(
        .width(width)
    ) u_step (
        .p    (p),
        .din  (dvd[width-1]),
        .dvs  (dvs),
        .p_nxt(p_nxt),
        .qbit (qbit)
    );

    assign dvd_nxt = {dvd[width-2:0], qbit};

    // next state and handshake outputs
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = (b != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = (b != '0) ? S_RUN : S_DONE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            p           <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd <= a;
            dvs <= b;
            p   <= '0;
            if (b != '0) begin
                cnt <= CW'(width - 1);
            end else begin
                q           <= '1;
                r           <= a;
                div_by_zero <= 1'b1;
            end
        end else if (state == S_RUN) begin
            p   <= p_nxt;
            dvd <= dvd_nxt;
            if (cnt == '0) begin
                q           <= dvd_nxt;
                r           <= p_nxt[width-1:0];
                div_by_zero <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench: 8-bit and 48-bit instances,
// scoreboard queues popped on each done pulse.
module tb_divider_iterative;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // cycle index, valid between posedges
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] q;
        logic [47:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    exp_t sb8[$];
    exp_t sb48[$];
    int   done_cnt8 = 0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ready8, busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    logic        start48 = 1'b0;
    logic [47:0] a48 = '0;
    logic [47:0] b48 = '0;
    logic        ready48, busy48, done48, dbz48;
    logic [47:0] q48, r48;

    divider_iterative #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8),
        .q(q8), .r(r8), .div_by_zero(dbz8)
    );

    divider_iterative dut48 (
        .clk(clk), .rst(rst), .start(start48),
        .a(a48), .b(b48),
        .ready(ready48), .busy(busy48), .done(done48),
        .q(q48), .r(r48), .div_by_zero(dbz48)
    );

    task automatic chk(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    exp_t e8;
    exp_t e48;
    logic [95:0] recon;

    // pop and compare 8-bit results on done
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (sb8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                e8 = sb8.pop_front();
                chk("q8", q8, e8.q);
                chk("r8", r8, e8.r);
                chk("dbz8", dbz8, e8.dbz);
                chk("lat8", cyc, e8.due);
            end
        end
    end

    // pop and compare 48-bit results, plus invariant
    always @(negedge clk) begin
        if (done48) begin
            if (sb48.size() == 0) begin
                chk("done48_unexpected", 1, 0);
            end else begin
                e48 = sb48.pop_front();
                chk("q48", q48, e48.q);
                chk("r48", r48, e48.r);
                chk("dbz48", dbz48, e48.dbz);
                chk("lat48", cyc, e48.due);
                if (e48.b != '0) begin
                    recon = {48'd0, q48} * {48'd0, e48.b}
                          + {48'd0, r48};
                    chk("inv48_qbr", recon, {48'd0, e48.a});
                    chk("inv48_rltb", (r48 < e48.b), 1);
                end
            end
        end
    end

    task automatic issue8(input logic [7:0] a, b, q, r,
                          input logic dbz, output int c);
        exp_t e;
        int n;
        n = 0;
        while (!ready8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready8_wait", ready8, 1);
        a8 = a; b8 = b; start8 = 1'b1;
        c = cyc;
        e.a = {40'd0, a}; e.b = {40'd0, b};
        e.q = {40'd0, q}; e.r = {40'd0, r};
        e.dbz = dbz;
        e.due = c + ((b == 8'd0) ? 1 : 9);
        sb8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic issue48(input logic [47:0] a, b, q, r,
                           input logic dbz);
        exp_t e;
        int n;
        n = 0;
        while (!ready48 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready48_wait", ready48, 1);
        a48 = a; b48 = b; start48 = 1'b1;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
        e.due = cyc + ((b == '0) ? 1 : 49);
        sb48.push_back(e);
        @(posedge clk); #1;
        start48 = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 8) ? sb8.size() : sb48.size()) != 0
               && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", (which == 8) ? sb8.size() : sb48.size(), 0);
    endtask

    vec_t tbl[6];

    initial begin
        int c;
        int d0;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [47:0] ta;
        logic [47:0] tb;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        tbl[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0};
        tbl[4] = '{8'd37,  8'd0,   8'hFF,  8'd37, 1'b1};
        tbl[5] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready8", ready8, 1);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_q8", q8, 0);
        chk("rst_r8", r8, 0);
        chk("rst_dbz8", dbz8, 0);
        chk("rst_ready48", ready48, 1);
        chk("rst_q48", q48, 0);

        for (int i = 0; i < 6; i++) begin
            issue8(tbl[i].a, tbl[i].b, tbl[i].q,
                   tbl[i].r, tbl[i].dbz, c);
            drain(8);
        end

        // RUN window: ready low, stray start ignored,
        // then back-to-back start in the DONE cycle
        d0 = done_cnt8;
        issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, c);
        for (int k = 1; k <= 8; k++) begin
            chk("run_ready8", ready8, 0);
            chk("run_busy8", busy8, 1);
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
            end
            if (k == 4) start8 = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_done8", done8, 1);
        begin
            exp_t e;
            a8 = 8'd81; b8 = 8'd9; start8 = 1'b1;
            e.a = 48'd81; e.b = 48'd9;
            e.q = 48'd9; e.r = 48'd0; e.dbz = 1'b0;
            e.due = cyc + 9;
            sb8.push_back(e);
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        drain(8);
        repeat (12) @(posedge clk);
        #1 chk("b2b_done_count", done_cnt8 - d0, 2);

        // reset in cycle 4 of a run discards it
        issue8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, c);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb8.delete();
        d0 = done_cnt8;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready8", ready8, 1);
        chk("mid_rst_busy8", busy8, 0);
        chk("mid_rst_q8", q8, 0);
        chk("mid_rst_r8", r8, 0);
        repeat (20) @(posedge clk);
        #1 chk("mid_rst_no_done", done_cnt8 - d0, 0);

        // 48-bit directed and random
        issue48(48'hFFFF_FFFF_FFFF, 48'd3,
                48'h5555_5555_5555, 48'd0, 1'b0);
        drain(48);
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            ta = ra[47:0];
            tb = rb[47:0] >> $urandom_range(0, 47);
            if (i % 100 == 7) tb = '0;
            if (tb == '0)
                issue48(ta, tb, '1, ta, 1'b1);
            else
                issue48(ta, tb, ta / tb, ta % tb, 1'b0);
        end
        drain(48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
